// File: rtl/dbus_pkg.sv
// Shared definitions for the Yduck data-bus controller.
//   - dbus_state_t : controller FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//   - REGION_*     : default region map (select value of each slave)
//   - sel_field()  : extracts the region-select field from an address
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dbus_state_t;

    // Default region map: select value 0 is RAM, select value 1 is GPIO.
    localparam int REGION_RAM  = 0;
    localparam int REGION_GPIO = 1;

    // Returns addr[aw-1:aw-sw] as an unsigned integer. The address is passed
    // zero-extended to 64 bits so one helper serves every address width.
    function automatic int unsigned sel_field(input logic [63:0] addr,
                                              input int          aw,
                                              input int          sw);
        logic [63:0] shifted;
        logic [63:0] masked;
        shifted = addr >> (aw - sw);
        masked  = shifted & ((64'd1 << sw) - 64'd1);
        return masked[31:0];
    endfunction

endpackage

// File: rtl/dbus_timeout.sv
// Wait-state watchdog for dbus_ctrl.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (asserted when a transfer enters WAIT)
//   en       : a WAIT cycle in which the selected slave is not ready
//   expire   : this stalled cycle is the (2^TO_W-1)th one; abort the transfer
module dbus_timeout #(
    parameter int TO_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // The counter holds the number of stalled cycles already completed, so
    // during the cycle where it reads 2^TO_W-2 the count reaches 2^TO_W-1.
    // Expiring here makes WAIT last exactly 2^TO_W-1 cycles.
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'((1 << TO_W) - 2);

    logic [TO_W-1:0] cnt_reg;
    logic [TO_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign expire = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/dbus_ctrl.sv
// Single-master data-bus controller.
// Decodes addr[AW-1:AW-SW] into one of NS slave regions, holds a one-hot
// request to that slave until it is ready, then completes with a one-cycle
// m_ready pulse. Unmapped selects (>= NS) complete with m_err and capture the
// faulting address in err_addr.
//
// Optional feature macro: DBUS_TIMEOUT_EN -- when defined, a transfer stalled
// for 2^TO_W-1 WAIT cycles is aborted with a bus error.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   m_req/m_we        : master request (held until m_ready) / write enable
//   m_addr/m_din      : master address / write data
//   m_dout            : registered read data, valid with m_ready
//   m_ready/m_err     : completion pulse / error qualifier
//   s_req[NS]         : one-hot slave request
//   s_we              : slave write enable (only while requesting)
//   s_addr/s_din      : latched address / write data, broadcast
//   s_dout[NS*DW]     : slave read data, slave k at [k*DW +: DW]
//   s_ready[NS]       : slave ready
//   err_addr          : address of the most recent erroring access (sticky)
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int SW   = 3,
    parameter int NS   = 2,
    parameter int TO_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_req,
    input  logic             m_we,
    input  logic [AW-1:0]    m_addr,
    input  logic [DW-1:0]    m_din,
    output logic [DW-1:0]    m_dout,
    output logic             m_ready,
    output logic             m_err,
    output logic [NS-1:0]    s_req,
    output logic             s_we,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_din,
    input  logic [NS*DW-1:0] s_dout,
    input  logic [NS-1:0]    s_ready,
    output logic [AW-1:0]    err_addr
);

    dbus_state_t state_reg;
    dbus_state_t state_next;

    // Latched transaction
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] din_reg;
    logic          we_reg;
    logic [SW-1:0] sel_reg;
    logic          err_flag_reg;
    logic [AW-1:0] err_addr_reg;
    logic [DW-1:0] m_dout_reg;

    // Decode / mux
    logic [SW-1:0] sel_in;
    logic          mapped;
    logic [NS-1:0] sel_hot;
    logic          sel_ready;
    logic [DW-1:0] slot [NS];
    logic [DW-1:0] rd_data;
    logic          to_expire;

    // FSM strobes into the datapath
    logic          load_req;
    logic          set_err;
    logic [AW-1:0] err_addr_src;
    logic          cap_rd;
    logic [DW-1:0] cap_data;

    assign sel_in = SW'(sel_field(64'(m_addr), AW, SW));
    assign mapped = (int'(sel_in) < NS);

    // One-hot decode of the latched select, slave data slots and requests.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slave
            assign sel_hot[gi] = (sel_reg == SW'(gi));
            assign slot[gi]    = s_dout[gi*DW +: DW];
            assign s_req[gi]   = (state_reg == ST_WAIT) && sel_hot[gi];
        end
    endgenerate

    // Ready bits from non-selected slaves are masked off.
    assign sel_ready = |(s_ready & sel_hot);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NS; k++) begin
            if (sel_hot[k]) begin
                rd_data = slot[k];
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    logic to_en;

    assign to_en = (state_reg == ST_WAIT) && !sel_ready;

    dbus_timeout #(
        .TO_W(TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (load_req),
        .en     (to_en),
        .expire (to_expire)
    );
`else
    logic unused_to_w;

    assign unused_to_w = (TO_W > 0);
    assign to_expire   = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        load_req     = 1'b0;
        set_err      = 1'b0;
        err_addr_src = '0;
        cap_rd       = 1'b0;
        cap_data     = '0;
        case (state_reg)
            ST_IDLE: begin
                if (m_req) begin
                    load_req = 1'b1;
                    if (mapped) begin
                        state_next = ST_WAIT;
                    end else begin
                        // Unmapped: complete at once; a read returns zero.
                        set_err      = 1'b1;
                        err_addr_src = m_addr;
                        cap_rd       = !m_we;
                        state_next   = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // A ready in the expiry cycle takes priority over the abort.
                if (sel_ready) begin
                    cap_rd     = !we_reg;
                    cap_data   = rd_data;
                    state_next = ST_RESP;
                end else if (to_expire) begin
                    set_err      = 1'b1;
                    err_addr_src = addr_reg;
                    cap_rd       = !we_reg;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= '0;
            din_reg      <= '0;
            we_reg       <= 1'b0;
            sel_reg      <= '0;
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
            m_dout_reg   <= '0;
        end else begin
            if (load_req) begin
                addr_reg <= m_addr;
                din_reg  <= m_din;
                we_reg   <= m_we;
                sel_reg  <= sel_in;
            end
            // The flag is cleared on every accepted request and set by either
            // error source; both can coincide for an unmapped access.
            if (load_req || set_err) begin
                err_flag_reg <= set_err;
            end
            if (set_err) begin
                err_addr_reg <= err_addr_src;
            end
            if (cap_rd) begin
                m_dout_reg <= cap_data;
            end
        end
    end

    // ------------------------------------------------------------- Outputs
    assign m_ready  = (state_reg == ST_RESP);
    assign m_err    = (state_reg == ST_RESP) && err_flag_reg;
    assign m_dout   = m_dout_reg;
    assign s_we     = (state_reg == ST_WAIT) && we_reg;
    assign s_addr   = addr_reg;
    assign s_din    = din_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl (DW=16, AW=16, SW=3, NS=2, TO_W=4).
// Each transaction is planned from the bus rules with plain arithmetic
// (completion offset, request window, error outcome); a single compare
// process checks every DUT output against that plan on each falling edge.
// Follows DBUS_TIMEOUT_EN in the same way as the design.
module tb_dbus_ctrl;

    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int SW     = 3;
    localparam int NS     = 2;
    localparam int TO_W   = 4;
    localparam int TO_MAX = (1 << TO_W) - 1;
`ifdef DBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             m_req;
    logic             m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_din;
    logic [DW-1:0]    m_dout;
    logic             m_ready;
    logic             m_err;
    logic [NS-1:0]    s_req;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_din;
    logic [NS*DW-1:0] s_dout;
    logic [NS-1:0]    s_ready;
    logic [AW-1:0]    err_addr;

    dbus_ctrl #(
        .DW(DW), .AW(AW), .SW(SW), .NS(NS), .TO_W(TO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_din    (m_din),
        .m_dout   (m_dout),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .s_ready  (s_ready),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;
    bit chk_en  = 1'b0;

    // Model state (what the outputs hold between transactions)
    logic [DW-1:0] mdl_dout;
    logic [AW-1:0] mdl_err_addr;
    logic [AW-1:0] mdl_s_addr;
    logic [DW-1:0] mdl_s_din;

    // Expected outputs for the current cycle
    logic [NS-1:0] exp_s_req;
    logic          exp_s_we;
    logic          exp_m_ready;
    logic          exp_m_err;
    logic [DW-1:0] exp_m_dout;
    logic [AW-1:0] exp_err_addr;
    logic [AW-1:0] exp_s_addr;
    logic [DW-1:0] exp_s_din;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready",  64'(m_ready),  64'(exp_m_ready));
            check("m_err",    64'(m_err),    64'(exp_m_err));
            check("m_dout",   64'(m_dout),   64'(exp_m_dout));
            check("s_req",    64'(s_req),    64'(exp_s_req));
            check("s_we",     64'(s_we),     64'(exp_s_we));
            check("s_addr",   64'(s_addr),   64'(exp_s_addr));
            check("s_din",    64'(s_din),    64'(exp_s_din));
            check("err_addr", 64'(err_addr), 64'(exp_err_addr));
        end
    end

    task automatic model_zero();
        mdl_dout     = '0;
        mdl_err_addr = '0;
        mdl_s_addr   = '0;
        mdl_s_din    = '0;
    endtask

    task automatic exp_quiet();
        exp_s_req    = '0;
        exp_s_we     = 1'b0;
        exp_m_ready  = 1'b0;
        exp_m_err    = 1'b0;
        exp_m_dout   = mdl_dout;
        exp_err_addr = mdl_err_addr;
        exp_s_addr   = mdl_s_addr;
        exp_s_din    = mdl_s_din;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m_req   = 1'b0;
            m_we    = 1'($urandom);
            m_addr  = 16'($urandom);
            m_din   = 16'($urandom);
            s_ready = 2'($urandom);
            s_dout  = $urandom;
            exp_quiet();
        end
    endtask

    // One master transaction starting in an IDLE cycle (offset 0).
    // delay: slave ready arrives in WAIT offset 1+delay.
    // abort_at: offset at which rst is raised (-1 for none).
    // Returns in the completion cycle (or the first cycle after a reset).
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                          input int delay, input logic [DW-1:0] rdata, input int abort_at);
        int sel;
        bit mapped;
        bit tout;
        bit err;
        bit aborted;
        int last_wait;
        int done;
        sel       = int'(addr[AW-1:AW-SW]);
        mapped    = sel < NS;
        tout      = mapped && TO_EN && (delay >= TO_MAX);
        last_wait = tout ? TO_MAX : 1 + delay;
        done      = !mapped ? 1 : last_wait + 1;
        err       = !mapped || tout;
        aborted   = 1'b0;
        n_txn++;
        $display("txn %0d: %s addr=0x%04h din=0x%04h delay=%0d done@+%0d err=%0d abort@%0d",
                 n_txn, we ? "WR" : "RD", addr, din, delay, done, err, abort_at);
        for (int c = 0; c <= done; c++) begin
            @(posedge clk); #1;
            m_req   = 1'b1;
            m_we    = we;
            m_addr  = addr;
            m_din   = din;
            s_ready = 2'($urandom);
            s_dout  = $urandom;
            if (mapped) begin
                s_ready[sel] = (c == 1 + delay) && (c <= last_wait);
                if (c == 1 + delay) s_dout[sel*DW +: DW] = rdata;
            end
            if (c == 1) begin
                mdl_s_addr = addr;
                mdl_s_din  = din;
            end
            if (c == done) begin
                if (!we) mdl_dout = err ? 16'h0000 : rdata;
                if (err) mdl_err_addr = addr;
            end
            exp_s_req    = (mapped && c >= 1 && c <= last_wait) ? 2'(1 << sel) : 2'b00;
            exp_s_we     = (exp_s_req != 2'b00) && we;
            exp_m_ready  = (c == done);
            exp_m_err    = (c == done) && err;
            exp_m_dout   = mdl_dout;
            exp_err_addr = mdl_err_addr;
            exp_s_addr   = mdl_s_addr;
            exp_s_din    = mdl_s_din;
            if (c == abort_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            rst   = 1'b0;
            m_req = 1'b0;
            model_zero();
            exp_quiet();
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_din   = '0;
        s_dout  = '0;
        s_ready = '0;
        model_zero();
        exp_quiet();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_m_dout",   64'(m_dout),   64'h0);
        check("reset_err_addr", 64'(err_addr), 64'h0);
        check("reset_s_req",    64'(s_req),    64'h0);
        idle(1);

        // Read to slave 0, ready in first WAIT cycle
        do_txn(1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, -1); #2;
        check("rd0_m_ready", 64'(m_ready), 64'h1);
        check("rd0_m_err",   64'(m_err),   64'h0);
        check("rd0_m_dout",  64'(m_dout),  64'hBEEF);
        idle(1);

        // Write to slave 1 after 3 wait cycles
        do_txn(1'b1, 16'h2004, 16'h1234, 3, 16'hDEAD, -1); #2;
        check("wr1_m_ready", 64'(m_ready), 64'h1);
        check("wr1_m_dout",  64'(m_dout),  64'hBEEF);
        check("wr1_s_din",   64'(s_din),   64'h1234);

        // Unmapped read (sel=3)
        do_txn(1'b0, 16'h6000, 16'h0000, 0, 16'h5555, -1); #2;
        check("unm_m_err",    64'(m_err),    64'h1);
        check("unm_m_dout",   64'(m_dout),   64'h0);
        check("unm_err_addr", 64'(err_addr), 64'h6000);

        // Hung slave 0
        do_txn(1'b0, 16'h0020, 16'h0000, 40, 16'h7777, -1); #2;
`ifdef DBUS_TIMEOUT_EN
        check("to_m_err",    64'(m_err),    64'h1);
        check("to_err_addr", 64'(err_addr), 64'h0020);
`else
        check("to_m_err",    64'(m_err),    64'h0);
        check("to_m_dout",   64'(m_dout),   64'h7777);
`endif

        // Reset in WAIT offset 3 of a stalled read
        do_txn(1'b0, 16'h0030, 16'h0000, 200, 16'h0000, 3); #2;
        check("rst_err_addr", 64'(err_addr), 64'h0);
        check("rst_m_ready",  64'(m_ready),  64'h0);
        check("rst_s_req",    64'(s_req),    64'h0);

        // Back-to-back reads to slave 0 then slave 1
        do_txn(1'b0, 16'h0100, 16'h0000, 0, 16'hA5A5, -1); #2;
        check("b2b0_m_dout", 64'(m_dout), 64'hA5A5);
        do_txn(1'b0, 16'h2200, 16'h0000, 0, 16'h5A5A, -1); #2;
        check("b2b1_m_dout", 64'(m_dout), 64'h5A5A);

        // Timeout boundary: ready in the 15th WAIT cycle wins, 16th is too late
        do_txn(1'b0, 16'h0040, 16'h0000, TO_MAX - 1, 16'h1357, -1);
        do_txn(1'b1, 16'h2040, 16'h2468, TO_MAX, 16'h0000, -1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            logic          we;
            logic [AW-1:0] addr;
            int            delay;
            int            abort_at;
            we       = 1'($urandom);
            addr     = 16'($urandom);
            if ($urandom_range(0, 3) != 0) addr[AW-1:AW-SW] = 3'($urandom_range(0, NS - 1));
            delay    = int'($urandom_range(0, 18));
            abort_at = -1;
            if ($urandom_range(0, 39) == 0) begin
                delay    = 100;
                abort_at = int'($urandom_range(1, 3));
            end
            do_txn(we, addr, 16'($urandom), delay, 16'($urandom), abort_at);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
